tdpr_port_arbiter: RTL and testbench

- Access controller between two independent clients and the true dual-port RAM (ADDR_SIZE=8, DATA_SIZE=8, one clock, synchronous 1-cycle read).
- Client A maps to RAM port A and client B to RAM port B. Each client uses a req/ready handshake.
- Detects same-address conflicts where at least one side writes, grants one side by round-robin and stalls the other.
- Returns read data with a registered valid flag and counts conflicts.

---
 rtl/tdpr_port_arbiter.sv | 94 +++++++++
 tb/tb_tdpr_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tdpr_port_arbiter.sv
// Two-client access controller for a true dual-port RAM.
// Resolves same-address write conflicts by round-robin and returns reads.
module tdpr_port_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_a,
    input  logic                 we_a,
    input  logic [ADDR_SIZE-1:0] addr_a,
    input  logic [DATA_SIZE-1:0] wdata_a,
    output logic                 ready_a,
    output logic [DATA_SIZE-1:0] rdata_a,
    output logic                 rvalid_a,
    input  logic                 req_b,
    input  logic                 we_b,
    input  logic [ADDR_SIZE-1:0] addr_b,
    input  logic [DATA_SIZE-1:0] wdata_b,
    output logic                 ready_b,
    output logic [DATA_SIZE-1:0] rdata_b,
    output logic                 rvalid_b,
    output logic                 ram_en_a,
    output logic                 ram_we_a,
    output logic [ADDR_SIZE-1:0] ram_addr_a,
    output logic [DATA_SIZE-1:0] ram_din_a,
    input  logic [DATA_SIZE-1:0] ram_dout_a,
    output logic                 ram_en_b,
    output logic                 ram_we_b,
    output logic [ADDR_SIZE-1:0] ram_addr_b,
    output logic [DATA_SIZE-1:0] ram_din_b,
    input  logic [DATA_SIZE-1:0] ram_dout_b,
    output logic                 prio_b,
    output logic [CNT_W-1:0]     coll_cnt
);

    logic conflict;
    logic grant_a;
    logic grant_b;

    // Conflict detection and grant; reset masks all grants combinationally
    always_comb begin
        conflict = req_a & req_b & (addr_a == addr_b) & (we_a | we_b);
        grant_a  = req_a & (~conflict | ~prio_b);
        grant_b  = req_b & (~conflict | prio_b);
        ready_a  = rst_n & grant_a;
        ready_b  = rst_n & grant_b;
    end

    // RAM port drive: enable only on an accepted transfer
    always_comb begin
        ram_en_a   = ready_a;
        ram_we_a   = we_a & ready_a;
        ram_addr_a = addr_a;
        ram_din_a  = wdata_a;
        ram_en_b   = ready_b;
        ram_we_b   = we_b & ready_b;
        ram_addr_b = addr_b;
        ram_din_b  = wdata_b;
        rdata_a    = ram_dout_a;
        rdata_b    = ram_dout_b;
    end

    // Read-valid flags follow accepted reads by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= ready_a & ~we_a;
            rvalid_b <= ready_b & ~we_b;
        end
    end

    // Round-robin pointer flips on every conflict so the loser wins next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b <= 1'b0;
        end else if (conflict) begin
            prio_b <= ~prio_b;
        end
    end

    // Saturating conflict counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt <= '0;
        end else if (conflict && (coll_cnt != {CNT_W{1'b1}})) begin
            coll_cnt <= coll_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tdpr_port_arbiter.sv
// Bench for tdpr_port_arbiter with a behavioural dual-port RAM.
// Expected grants and read data come from a reference model and queue.
module tb_tdpr_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic          req_a, we_a, req_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          ready_a, ready_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_din_b;
    logic [DW-1:0] ram_dout_a, ram_dout_b;
    logic          prio_b;
    logic [CW-1:0] coll_cnt;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];
    logic          mprio;
    int            mcnt;
    int            checks;
    int            errors;

    tdpr_port_arbiter #(
        .ADDR_SIZE(AW),
        .DATA_SIZE(DW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_a(req_a),
        .we_a(we_a),
        .addr_a(addr_a),
        .wdata_a(wdata_a),
        .ready_a(ready_a),
        .rdata_a(rdata_a),
        .rvalid_a(rvalid_a),
        .req_b(req_b),
        .we_b(we_b),
        .addr_b(addr_b),
        .wdata_b(wdata_b),
        .ready_b(ready_b),
        .rdata_b(rdata_b),
        .rvalid_b(rvalid_b),
        .ram_en_a(ram_en_a),
        .ram_we_a(ram_we_a),
        .ram_addr_a(ram_addr_a),
        .ram_din_a(ram_din_a),
        .ram_dout_a(ram_dout_a),
        .ram_en_b(ram_en_b),
        .ram_we_b(ram_we_b),
        .ram_addr_b(ram_addr_b),
        .ram_din_b(ram_din_b),
        .ram_dout_b(ram_dout_b),
        .prio_b(prio_b),
        .coll_cnt(coll_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural true dual-port RAM with registered read
    always @(posedge clk) begin
        if (ram_en_a) begin
            if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
            else ram_dout_a <= mem[ram_addr_a];
        end
        if (ram_en_b) begin
            if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
            else ram_dout_b <= mem[ram_addr_b];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check grants and returned reads, advance model
    task automatic step(input logic ra, input logic wa, input logic [AW-1:0] aa,
                        input logic [DW-1:0] da, input logic rb, input logic wb,
                        input logic [AW-1:0] ab, input logic [DW-1:0] db);
        logic conf, era, erb;
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        #1;
        conf = ra & rb & (aa == ab) & (wa | wb);
        era  = ra & (~conf | ~mprio);
        erb  = rb & (~conf | mprio);
        check("ready_a", ready_a, era);
        check("ready_b", ready_b, erb);
        check("ram_we_a", ram_we_a, era & wa);
        check("ram_we_b", ram_we_b, erb & wb);
        check("rvalid_a", rvalid_a, qa.size() != 0);
        check("rvalid_b", rvalid_b, qb.size() != 0);
        if (qa.size() != 0) check("rdata_a", rdata_a, qa.pop_front());
        if (qb.size() != 0) check("rdata_b", rdata_b, qb.pop_front());
        @(posedge clk);
        if (era && !wa) qa.push_back(shadow[aa]);
        if (erb && !wb) qb.push_back(shadow[ab]);
        if (era && wa) shadow[aa] = da;
        if (erb && wb) shadow[ab] = db;
        if (conf) begin
            mprio = ~mprio;
            if (mcnt < 3) mcnt++;
        end
        @(negedge clk);
        check("prio_b", prio_b, mprio);
        check("coll_cnt", coll_cnt, mcnt);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mprio  = 1'b0;
        mcnt   = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        ram_dout_a = '0;
        ram_dout_b = '0;
        rst_n = 1'b0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h40; wdata_a = 8'h01;
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'h40; wdata_b = 8'h02;
        repeat (2) @(posedge clk);
        #1;
        check("rst ready_a", ready_a, 1'b0);
        check("rst ready_b", ready_b, 1'b0);
        check("rst ram_en_a", ram_en_a, 1'b0);
        check("rst ram_en_b", ram_en_b, 1'b0);
        check("rst rvalid_a", rvalid_a, 1'b0);
        check("rst rvalid_b", rvalid_b, 1'b0);
        check("rst prio_b", prio_b, 1'b0);
        check("rst coll_cnt", coll_cnt, 0);
        check("rst mem", mem[8'h40], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Independent writes, then crossed reads
        step(1, 1, 8'h10, 8'h5A, 1, 1, 8'h20, 8'hC3);
        step(1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 8'h00);
        // Same-address read/read is not a conflict
        step(1, 0, 8'h10, 8'h00, 1, 0, 8'h10, 8'h00);
        idle();

        // Write/write conflict: A then B, B's data survives
        step(1, 1, 8'h40, 8'h11, 1, 1, 8'h40, 8'h22);
        step(0, 1, 8'h40, 8'h11, 1, 1, 8'h40, 8'h22);
        step(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00);
        idle();
        check("ww final", mem[8'h40], 8'h22);

        // Read/write fairness on 0x80 seeded with an old value
        step(1, 1, 8'h80, 8'h33, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++)
            step(1, 0, 8'h80, 8'h00, 1, 1, 8'h80, 8'h77);
        idle();

        // More conflicts: counter must hold at its maximum
        for (int i = 0; i < 3; i++)
            step(1, 1, 8'h05, 8'h40 + 8'(i), 1, 1, 8'h05, 8'h50 + 8'(i));

        // Reset while a read return is pending
        step(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h90; wdata_a = 8'hEE;
        req_b = 1'b1; we_b = 1'b0; addr_b = 8'h90;
        rst_n = 1'b0;
        #1;
        check("mid rvalid_a", rvalid_a, 1'b0);
        check("mid rvalid_b", rvalid_b, 1'b0);
        check("mid coll_cnt", coll_cnt, 0);
        check("mid prio_b", prio_b, 1'b0);
        check("mid ready_a", ready_a, 1'b0);
        check("mid ram_en_b", ram_en_b, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("mid no write", mem[8'h90], 8'h00);
        qa.delete();
        qb.delete();
        mprio = 1'b0;
        mcnt  = 0;
        rst_n = 1'b1;
        step(1, 0, 8'h40, 8'h00, 1, 0, 8'h80, 8'h00);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
